rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares one DATA_SIZE-bit output channel among 2**SELECT_SIZE requesters.
//  - Generates the port select for the indexed input mux and steers the chosen input's data to the output.
//  - Handshakes are valid/ready on every side.
//  - A grant is held for a whole packet (until last), or until MAX_BEATS beats have transferred.
//  - Sits in front of shared sinks (UART TX, LED/PWM register bank) that several producers feed.
// PARAMETERS
//  DATA_SIZE    1  width of each data beat
//  SELECT_SIZE  1  select width; N = 2**SELECT_SIZE requesters
//  MAX_BEATS    0  0 = hold grant until last; >0 = force release after this many beats
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   N          requester i has a beat
//  req_data   in   DATA_SIZE  unpacked array [N-1:0], beat from requester i
//  req_last   in   N          beat from requester i ends its packet
//  req_ready  out  N          beat from requester i accepted this cycle
//  out_valid  out  1          output beat valid
//  out_data   out  DATA_SIZE  output beat = req_data[grant_port]
//  out_last   out  1          end of grant (packet end or forced release)
//  out_ready  in   1          sink accepts beat
//  grant_port out  SELECT_SIZE  current mux select
//  busy       out  1          1 while in LOCKED
// BEHAVIOUR
//  Clocking and reset
//  - One clock. Reset is asynchronous and active-low.
//  - On rst_n=0: state=IDLE, grant_port=0, last_grant=N-1, beat_cnt=0.
//  - Outputs during and after reset: out_valid=0, req_ready=0, busy=0, out_last=0.
//  - Reset mid-packet drops the grant immediately. No beat is transferred while rst_n=0.
//  States
//  - IDLE:
//    - out_valid=0 and req_ready=0.
//    - If any req_valid is set, the winner is the first i with req_valid[i], searching
//      last_grant+1, +2, ... mod N.
//    - Next cycle: grant_port=winner, beat_cnt=0, state=LOCKED.
//    - Arbitration latency is 1 cycle. The grant is decided from req_valid only.
//  - LOCKED:
//    - out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready, all other
//      req_ready=0 (g = grant_port).
//    - Transfer happens when out_valid && out_ready. On each transfer, beat_cnt increments.
//    - Release condition: transfer && (req_last[g] || (MAX_BEATS>0 && beat_cnt==MAX_BEATS-1)).
//    - out_last = req_valid[g] && that release condition (without the ready term).
//    - On release: last_grant<=g, state=IDLE. This leaves a one-cycle bubble between grants.
//  Datapath and width rules
//  - out_data and req_ready are combinational from grant_port (mux path). busy and grant_port
//    are registers.
//  - beat_cnt has clog2(MAX_BEATS+1) bits (min 1) and never wraps past MAX_BEATS-1.
//    It is unused when MAX_BEATS=0.
//  Boundary conditions
//  - Granted requester drops req_valid mid-packet: the grant is held and out_valid=0
//    (no starvation release).
//  - Other requesters asserting valid while LOCKED are ignored until IDLE.
//  - N=1 (SELECT_SIZE=0 not supported): SELECT_SIZE>=1 is required.
//  - out_ready low: out_valid holds, req_ready=0, and no state change.
//  - Single-beat packet (req_last on first beat): LOCKED lasts exactly one transfer cycle.
// TESTING
//  1. Reset: hold rst_n=0 with all req_valid=1 -> out_valid=0, req_ready=0, busy=0.
//     Release reset -> first grant is port 0.
//  2. Fairness: N=4, all req_valid=1, each packet 1 beat with last, out_ready=1
//     -> grant order 0,1,2,3,0 with one idle cycle between each.
//  3. Packet lock: port 1 sends a 3-beat packet, port 2 requests at beat 1 -> port 2 granted
//     only after port 1's last beat. out_data matches port 1 for all 3 beats.
//  4. Backpressure: out_ready=0 for 5 cycles mid-packet -> out_valid stays 1, no req_ready,
//     and beat count unchanged.
//  5. MAX_BEATS=2: port 0 streams 5 beats with no last -> release after 2 beats with
//     out_last=1, then port 0 is re-granted if alone.
//  6. Async reset at beat 2 of a 4-beat packet -> outputs go idle without a clock edge.
//     After reset, port 0 has priority.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin packet arbiter steering 2**SELECT_SIZE requesters onto one valid/ready channel
module rr_mux_arbiter #(
   parameter int DATA_SIZE   = 1,
   parameter int SELECT_SIZE = 1,
   parameter int MAX_BEATS   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [2**SELECT_SIZE-1:0]    req_valid,
   input  logic [DATA_SIZE-1:0]         req_data [2**SELECT_SIZE-1:0],
   input  logic [2**SELECT_SIZE-1:0]    req_last,
   output logic [2**SELECT_SIZE-1:0]    req_ready,
   output logic                         out_valid,
   output logic [DATA_SIZE-1:0]         out_data,
   output logic                         out_last,
   input  logic                         out_ready,
   output logic [SELECT_SIZE-1:0]       grant_port,
   output logic                         busy
);
   localparam int N  = 2**SELECT_SIZE;
   localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (MAX_BEATS > 0) ? CW'(MAX_BEATS - 1) : '0;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]             state;
   logic [SELECT_SIZE-1:0] last_grant;
   logic [CW-1:0]          beat_cnt;
   logic [SELECT_SIZE-1:0] winner;
   logic [SELECT_SIZE-1:0] cand;
   logic                   locked;
   logic                   xfer;
   logic                   at_limit;
   logic                   release_cond;

   // Scan from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      winner = last_grant;
      cand   = '0;
      for (int i = N; i >= 1; i--) begin
         cand = last_grant + SELECT_SIZE'(i);
         if (req_valid[cand]) begin
            winner = cand;
         end
      end
   end

   assign locked       = (state == ST_LOCKED);
   assign busy         = locked;
   assign out_data     = req_data[grant_port];
   assign out_valid    = locked && req_valid[grant_port];
   assign xfer         = out_valid && out_ready;
   assign at_limit     = (MAX_BEATS > 0) && (beat_cnt == CNT_LAST);
   assign out_last     = out_valid && (req_last[grant_port] || at_limit);
   assign release_cond = xfer && (req_last[grant_port] || at_limit);

   always_comb begin
      req_ready = '0;
      if (locked && out_ready) begin
         req_ready[grant_port] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         grant_port <= '0;
         last_grant <= '1;
         beat_cnt   <= '0;
      end else if (state == ST_IDLE) begin
         if (|req_valid) begin
            state      <= ST_LOCKED;
            grant_port <= winner;
            beat_cnt   <= '0;
         end
      end else begin
         if (release_cond) begin
            state      <= ST_IDLE;
            last_grant <= grant_port;
            beat_cnt   <= '0;
         end else if (xfer && (MAX_BEATS > 0)) begin
            beat_cnt <= beat_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed and randomized checks of rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;
   localparam int SS = 2;
   localparam int N  = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_last;
   logic [DW-1:0] req_data [N-1:0];
   logic          out_ready;

   logic [N-1:0]  req_ready  [2];
   logic          out_valid  [2];
   logic [DW-1:0] out_data   [2];
   logic          out_last   [2];
   logic [SS-1:0] grant_port [2];
   logic          busy       [2];

   rr_mux_arbiter #(.DATA_SIZE(DW), .SELECT_SIZE(SS), .MAX_BEATS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready[0]), .out_valid(out_valid[0]),
      .out_data(out_data[0]), .out_last(out_last[0]), .out_ready(out_ready),
      .grant_port(grant_port[0]), .busy(busy[0]));

   rr_mux_arbiter #(.DATA_SIZE(DW), .SELECT_SIZE(SS), .MAX_BEATS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready[1]), .out_valid(out_valid[1]),
      .out_data(out_data[1]), .out_last(out_last[1]), .out_ready(out_ready),
      .grant_port(grant_port[1]), .busy(busy[1]));

   always #5 clk = ~clk;

   // Model: owner = granted port or -1, prev = last granted, shown = mux select, beats = transfers in grant.
   int owner [2] = '{-1, -1};
   int prev  [2] = '{N-1, N-1};
   int shown [2] = '{0, 0};
   int beats [2] = '{0, 0};
   int mb    [2] = '{0, 2};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            owner[m] = -1;
            prev[m]  = N - 1;
            shown[m] = 0;
            beats[m] = 0;
         end else if (owner[m] < 0) begin
            if (req_valid != '0) begin
               bit found;
               found = 1'b0;
               for (int k = 1; k <= N; k++) begin
                  int c;
                  c = (prev[m] + k) % N;
                  if (!found && req_valid[c]) begin
                     owner[m] = c;
                     found    = 1'b1;
                  end
               end
               shown[m] = owner[m];
               beats[m] = 0;
            end
         end else if (req_valid[owner[m]] && out_ready) begin
            beats[m]++;
            if (req_last[owner[m]] || (mb[m] > 0 && beats[m] == mb[m])) begin
               prev[m]  = owner[m];
               owner[m] = -1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         int o;
         int ev;
         int el;
         int er;
         o  = owner[m];
         ev = 0;
         el = 0;
         er = 0;
         if (o >= 0) begin
            ev = int'(req_valid[o]);
            if (ev != 0 && (req_last[o] || (mb[m] > 0 && beats[m] == mb[m] - 1))) el = 1;
            if (out_ready) er = 1 << o;
         end
         check($sformatf("out_valid[%0d]", m), int'(out_valid[m]), ev);
         check($sformatf("out_last[%0d]", m), int'(out_last[m]), el);
         check($sformatf("req_ready[%0d]", m), int'(req_ready[m]), er);
         check($sformatf("busy[%0d]", m), int'(busy[m]), (o >= 0) ? 1 : 0);
         check($sformatf("grant_port[%0d]", m), int'(grant_port[m]), shown[m]);
         check($sformatf("out_data[%0d]", m), int'(out_data[m]), int'(req_data[shown[m]]));
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_last  = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) req_data[i] = 8'(8'h10 * (i + 1));

      // reset held with every requester valid
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", int'(out_valid[0]), 0);
         check("rst_req_ready", int'(req_ready[0]), 0);
         check("rst_busy", int'(busy[0]), 0);
      end
      cyc;
      rst_n = 1'b1;

      // single-beat packets from all ports: grants 0,1,2,3,0 with a bubble between
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("fair_busy", int'(busy[0]), k % 2);
         if (k % 2 == 1) check("fair_grant", int'(grant_port[0]), ((k - 1) / 2) % 4);
      end

      // packet lock: port 1 three beats, port 2 requests during beat 1
      cyc; rst_n = 1'b0; req_valid = '0; req_last = '0;
      cyc; rst_n = 1'b1; req_valid = 4'b0010; req_data[1] = 8'hA0;
      cyc;
      @(negedge clk);
      check("lock_grant", int'(grant_port[0]), 1);
      check("lock_beat0", int'(out_data[0]), 8'hA0);
      check("lock_ready", int'(req_ready[0]), 4'b0010);
      cyc; req_data[1] = 8'hA1; req_valid = 4'b0110;
      @(negedge clk);
      check("lock_beat1", int'(out_data[0]), 8'hA1);
      check("lock_hold", int'(grant_port[0]), 1);
      check("lock_nolast", int'(out_last[0]), 0);
      cyc; req_data[1] = 8'hA2; req_last = 4'b0010;
      @(negedge clk);
      check("lock_beat2", int'(out_data[0]), 8'hA2);
      check("lock_last", int'(out_last[0]), 1);
      cyc; req_valid = 4'b0100; req_last = '0; req_data[2] = 8'hB0;
      @(negedge clk);
      check("lock_bubble", int'(busy[0]), 0);
      cyc;
      @(negedge clk);
      check("lock_next_grant", int'(grant_port[0]), 2);
      check("lock_next_data", int'(out_data[0]), 8'hB0);

      // backpressure mid-packet on port 2
      cyc; out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", int'(out_valid[0]), 1);
         check("bp_ready", int'(req_ready[0]), 0);
         check("bp_grant", int'(grant_port[0]), 2);
         cyc;
      end
      out_ready = 1'b1; req_last = 4'b0100;
      @(negedge clk);
      check("bp_resume_last", int'(out_last[0]), 1);
      check("bp_resume_ready", int'(req_ready[0]), 4'b0100);
      cyc; req_valid = '0; req_last = '0;
      @(negedge clk);
      check("bp_release", int'(busy[0]), 0);

      // forced release after two beats on the MAX_BEATS=2 instance
      cyc; rst_n = 1'b0;
      cyc; rst_n = 1'b1; req_valid = 4'b0001; req_data[0] = 8'h50;
      cyc;
      @(negedge clk);
      check("max_grant", int'(grant_port[1]), 0);
      check("max_first_last", int'(out_last[1]), 0);
      cyc; req_data[0] = 8'h51;
      @(negedge clk);
      check("max_second_last", int'(out_last[1]), 1);
      cyc;
      @(negedge clk);
      check("max_bubble", int'(busy[1]), 0);
      check("max_unforced_busy", int'(busy[0]), 1);
      cyc;
      @(negedge clk);
      check("max_regrant_busy", int'(busy[1]), 1);
      check("max_regrant_port", int'(grant_port[1]), 0);
      check("max_regrant_last", int'(out_last[1]), 0);

      // asynchronous reset at beat 2 of a four-beat packet
      cyc; rst_n = 1'b0;
      cyc; rst_n = 1'b1; req_valid = 4'b0001; req_last = '0;
      cyc; cyc; cyc;
      @(negedge clk);
      check("arst_pre_valid", int'(out_valid[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", int'(out_valid[0]), 0);
      check("arst_req_ready", int'(req_ready[0]), 0);
      check("arst_busy", int'(busy[0]), 0);
      check("arst_out_last", int'(out_last[0]), 0);
      cyc; rst_n = 1'b1; req_valid = 4'hF; req_last = 4'hF;
      cyc;
      @(negedge clk);
      check("arst_first_grant", int'(grant_port[0]), 0);
      check("arst_first_busy", int'(busy[0]), 1);

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         cyc;
         req_valid = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            req_last[i] = ($urandom % 3) == 0;
            req_data[i] = 8'($urandom);
         end
         out_ready = ($urandom % 4) != 0;
         rst_n     = ($urandom % 250) != 0;
      end
      cyc;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
